// File: rtl/fpu_apu_scheduler.sv
// -----------------------------------------------------------------------------
// fpu_apu_scheduler
//
// Shares one APU master port of the FPU interconnect between NB_CORES cores.
// A round-robin arbiter picks one eligible requester per cycle and forwards
// its operands/opcode/flags with a one-hot core ID. The number of accepted
// but unanswered operations is capped at MAX_OUTSTANDING. Each core may have
// at most one operation in flight. Responses are routed back by their
// one-hot ID. A level-sensitive flush stops new issues and reports when all
// in-flight operations have returned.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   core_req_i        per-core request
//   core_gnt_o        per-core grant (at most one bit high)
//   core_operands_i   packed operands, core c at [c*NB_APU_ARGS*APU_DATA_WIDTH +: ...]
//   core_op_i         packed opcodes
//   core_flags_i      packed downstream flags
//   core_rvalid_o     per-core response valid
//   apu_req_o         request to the APU
//   apu_gnt_i         APU accepts the request
//   apu_ID_o          one-hot ID of the winning core
//   apu_operands_o    winner operands
//   apu_op_o          winner opcode
//   apu_flags_o       winner flags
//   apu_rvalid_i      APU response valid
//   apu_rID_i         one-hot ID of the response
//   flush_i           drain request (level)
//   drained_o         drain complete, nothing in flight
//   outstanding_o     current in-flight count
//   err_o             sticky protocol error (bad or unexpected response ID)
// -----------------------------------------------------------------------------
module fpu_apu_scheduler #(
    parameter int NB_CORES         = 4,
    parameter int NB_APU_ARGS      = 3,
    parameter int APU_DATA_WIDTH   = 64,
    parameter int APU_OPCODE_WIDTH = 5,
    parameter int APU_DSFLAGS_CPU  = 15,
    parameter int MAX_OUTSTANDING  = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NB_CORES-1:0]                            core_req_i,
    output logic [NB_CORES-1:0]                            core_gnt_o,
    input  logic [NB_CORES*NB_APU_ARGS*APU_DATA_WIDTH-1:0] core_operands_i,
    input  logic [NB_CORES*APU_OPCODE_WIDTH-1:0]           core_op_i,
    input  logic [NB_CORES*APU_DSFLAGS_CPU-1:0]            core_flags_i,
    output logic [NB_CORES-1:0]                            core_rvalid_o,
    output logic                                           apu_req_o,
    input  logic                                           apu_gnt_i,
    output logic [NB_CORES-1:0]                            apu_ID_o,
    output logic [NB_APU_ARGS*APU_DATA_WIDTH-1:0]          apu_operands_o,
    output logic [APU_OPCODE_WIDTH-1:0]                    apu_op_o,
    output logic [APU_DSFLAGS_CPU-1:0]                     apu_flags_o,
    input  logic                                           apu_rvalid_i,
    input  logic [NB_CORES-1:0]                            apu_rID_i,
    input  logic                                           flush_i,
    output logic                                           drained_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]           outstanding_o,
    output logic                                           err_o
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W  = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
    localparam int OPND_W = NB_APU_ARGS * APU_DATA_WIDTH;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_DRAINED = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NB_CORES-1:0] pending_q, pending_d;
    logic                err_q, err_d;

    logic [NB_CORES-1:0] eligible;
    logic [NB_CORES-1:0] elig_hi;
    logic [NB_CORES-1:0] winner_oh;
    logic [NB_CORES-1:0] sel_oh;
    logic [PTR_W-1:0]    winner_idx;
    logic                req_ok;
    logic                accept;
    logic [NB_CORES-1:0] resp_hit;
    logic                resp_match;
    logic                rid_onehot;
    logic                rid_stray;

    assign eligible = core_req_i & ~pending_q;

    // Round robin: eligible cores at or above rr_ptr take priority; if none,
    // wrap around to the lowest eligible core. x & -x isolates the lowest set bit.
    assign winner_oh = (|elig_hi) ? (elig_hi & (~elig_hi + 1'b1))
                                  : (eligible & (~eligible + 1'b1));

    // Reset also blanks the request so every output is low while rst is held.
    assign req_ok = !rst && (state_q == ST_RUN) &&
                    (cnt_q < CNT_W'(MAX_OUTSTANDING)) && (|eligible);
    assign accept = req_ok && apu_gnt_i;
    assign sel_oh = req_ok ? winner_oh : '0;

    // Per-core masking and OR-reduction chains for the winner's payload and index.
    // Each stage lives in its own generate scope so the chain is acyclic per signal.
    for (genvar gi = 0; gi < NB_CORES; gi++) begin : g_core
        logic [OPND_W-1:0]           opnd_acc;
        logic [APU_OPCODE_WIDTH-1:0] op_acc;
        logic [APU_DSFLAGS_CPU-1:0]  flags_acc;
        logic [PTR_W-1:0]            idx_acc;
        logic [OPND_W-1:0]           opnd_m;
        logic [APU_OPCODE_WIDTH-1:0] op_m;
        logic [APU_DSFLAGS_CPU-1:0]  flags_m;
        logic [PTR_W-1:0]            idx_m;

        assign elig_hi[gi] = eligible[gi] && (PTR_W'(gi) >= rr_ptr_q);
        assign opnd_m  = {OPND_W{sel_oh[gi]}} & core_operands_i[gi*OPND_W +: OPND_W];
        assign op_m    = {APU_OPCODE_WIDTH{sel_oh[gi]}} &
                         core_op_i[gi*APU_OPCODE_WIDTH +: APU_OPCODE_WIDTH];
        assign flags_m = {APU_DSFLAGS_CPU{sel_oh[gi]}} &
                         core_flags_i[gi*APU_DSFLAGS_CPU +: APU_DSFLAGS_CPU];
        assign idx_m   = winner_oh[gi] ? PTR_W'(gi) : '0;

        if (gi == 0) begin : g_first
            assign opnd_acc  = opnd_m;
            assign op_acc    = op_m;
            assign flags_acc = flags_m;
            assign idx_acc   = idx_m;
        end else begin : g_next
            assign opnd_acc  = g_core[gi-1].opnd_acc  | opnd_m;
            assign op_acc    = g_core[gi-1].op_acc    | op_m;
            assign flags_acc = g_core[gi-1].flags_acc | flags_m;
            assign idx_acc   = g_core[gi-1].idx_acc   | idx_m;
        end
    end

    assign winner_idx     = g_core[NB_CORES-1].idx_acc;
    assign apu_operands_o = g_core[NB_CORES-1].opnd_acc;
    assign apu_op_o       = g_core[NB_CORES-1].op_acc;
    assign apu_flags_o    = g_core[NB_CORES-1].flags_acc;
    assign apu_req_o      = req_ok;
    assign apu_ID_o       = sel_oh;
    assign core_gnt_o     = accept ? sel_oh : '0;

    // Response routing: only bits belonging to a pending core are delivered.
    assign resp_hit      = apu_rvalid_i ? (apu_rID_i & pending_q) : '0;
    assign resp_match    = |resp_hit;
    assign core_rvalid_o = resp_hit;
    assign rid_onehot    = (apu_rID_i != '0) && ((apu_rID_i & (apu_rID_i - 1'b1)) == '0);
    assign rid_stray     = (apu_rID_i & ~pending_q) != '0;

    always_comb begin
        // A newly accepted core is never pending, so the set and clear never collide.
        pending_d = (pending_q & ~resp_hit) | (accept ? winner_oh : '0);

        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (winner_idx == PTR_W'(NB_CORES - 1)) ? '0 : winner_idx + 1'b1;
        end

        cnt_d = cnt_q;
        if (accept && !resp_match) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && resp_match) begin
            cnt_d = cnt_q - 1'b1;
        end

        err_d = err_q | (apu_rvalid_i && (!rid_onehot || rid_stray));

        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((cnt_q == '0) && !resp_match) begin
                    state_d = flush_i ? ST_DRAINED : ST_RUN;
                end
            end
            ST_DRAINED: begin
                if (!flush_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign drained_o     = (state_q == ST_DRAINED);
    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_fpu_apu_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fpu_apu_scheduler
//
// Directed scenarios plus randomized traffic, each cycle compared against a
// behavioural model of the scheduler (pending set, round-robin pointer as an
// integer, in-flight count, operating mode).
// -----------------------------------------------------------------------------
module tb_fpu_apu_scheduler;

    localparam int NB     = 4;
    localparam int ARGS   = 3;
    localparam int DW     = 64;
    localparam int OPW    = 5;
    localparam int FW     = 15;
    localparam int MAXO   = 2;
    localparam int CW     = $clog2(MAXO + 1);
    localparam int OPND_W = ARGS * DW;

    localparam int MODE_RUN   = 0;
    localparam int MODE_DRAIN = 1;
    localparam int MODE_IDLE  = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NB-1:0]          core_req_i = '0;
    logic [NB-1:0]          core_gnt_o;
    logic [NB*OPND_W-1:0]   core_operands_i = '0;
    logic [NB*OPW-1:0]      core_op_i = '0;
    logic [NB*FW-1:0]       core_flags_i = '0;
    logic [NB-1:0]          core_rvalid_o;
    logic                   apu_req_o;
    logic                   apu_gnt_i = 1'b0;
    logic [NB-1:0]          apu_ID_o;
    logic [OPND_W-1:0]      apu_operands_o;
    logic [OPW-1:0]         apu_op_o;
    logic [FW-1:0]          apu_flags_o;
    logic                   apu_rvalid_i = 1'b0;
    logic [NB-1:0]          apu_rID_i = '0;
    logic                   flush_i = 1'b0;
    logic                   drained_o;
    logic [CW-1:0]          outstanding_o;
    logic                   err_o;

    fpu_apu_scheduler #(
        .NB_CORES         (NB),
        .NB_APU_ARGS      (ARGS),
        .APU_DATA_WIDTH   (DW),
        .APU_OPCODE_WIDTH (OPW),
        .APU_DSFLAGS_CPU  (FW),
        .MAX_OUTSTANDING  (MAXO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .core_req_i      (core_req_i),
        .core_gnt_o      (core_gnt_o),
        .core_operands_i (core_operands_i),
        .core_op_i       (core_op_i),
        .core_flags_i    (core_flags_i),
        .core_rvalid_o   (core_rvalid_o),
        .apu_req_o       (apu_req_o),
        .apu_gnt_i       (apu_gnt_i),
        .apu_ID_o        (apu_ID_o),
        .apu_operands_o  (apu_operands_o),
        .apu_op_o        (apu_op_o),
        .apu_flags_o     (apu_flags_o),
        .apu_rvalid_i    (apu_rvalid_i),
        .apu_rID_i       (apu_rID_i),
        .flush_i         (flush_i),
        .drained_o       (drained_o),
        .outstanding_o   (outstanding_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [NB-1:0] m_pend;
    int            m_rr;
    int            m_cnt;
    int            m_mode;
    logic          m_err;
    int            m_win;
    logic          m_req;
    logic          m_accept;

    // Snapshot of the last sampled outputs, for directed constant checks.
    logic [NB-1:0] last_id, last_gnt, last_rvalid;
    logic          last_req, last_drained, last_err;
    logic [CW-1:0] last_out;

    task automatic model_reset();
        m_pend = '0;
        m_rr   = 0;
        m_cnt  = 0;
        m_mode = MODE_RUN;
        m_err  = 1'b0;
    endtask

    task automatic model_eval();
        m_win = -1;
        for (int k = 0; k < NB; k++) begin
            int c;
            c = (m_rr + k) % NB;
            if (m_win < 0 && core_req_i[c] && !m_pend[c]) m_win = c;
        end
        m_req    = (m_mode == MODE_RUN) && (m_cnt < MAXO) && (m_win >= 0);
        m_accept = m_req && apu_gnt_i;
    endtask

    task automatic model_update();
        logic [NB-1:0] hit;
        logic          matched;
        hit     = apu_rvalid_i ? (apu_rID_i & m_pend) : '0;
        matched = (hit != '0);
        if (apu_rvalid_i && (($countones(apu_rID_i) != 1) || ((apu_rID_i & ~m_pend) != '0)))
            m_err = 1'b1;
        case (m_mode)
            MODE_RUN:   if (flush_i) m_mode = MODE_DRAIN;
            MODE_DRAIN: if (m_cnt == 0 && !matched) m_mode = flush_i ? MODE_IDLE : MODE_RUN;
            default:    if (!flush_i) m_mode = MODE_RUN;
        endcase
        m_pend = m_pend & ~hit;
        if (m_accept) begin
            m_pend[m_win] = 1'b1;
            m_rr = (m_win + 1) % NB;
            m_cnt++;
        end
        if (matched) m_cnt--;
    endtask

    // One clock cycle: drive inputs, check at the falling edge, advance the model.
    task automatic step(input logic [NB-1:0] req, input logic gnt, input logic rv,
                        input logic [NB-1:0] rid, input logic fl);
        int            w;
        logic [NB-1:0] exp_id;
        core_req_i   = req;
        apu_gnt_i    = gnt;
        apu_rvalid_i = rv;
        apu_rID_i    = rid;
        flush_i      = fl;
        for (int i = 0; i < NB * ARGS; i++) core_operands_i[i*DW +: DW] = {$urandom, $urandom};
        core_op_i    = $urandom;
        core_flags_i = {$urandom, $urandom};
        @(negedge clk);
        model_eval();
        w      = (m_win < 0) ? 0 : m_win;
        exp_id = m_req ? (NB'(1) << w) : '0;
        check_eq("apu_req", apu_req_o, m_req);
        check_eq("apu_ID", apu_ID_o, exp_id);
        check_eq("core_gnt", core_gnt_o, m_accept ? exp_id : '0);
        check_eq("apu_operands", apu_operands_o, m_req ? core_operands_i[w*OPND_W +: OPND_W] : '0);
        check_eq("apu_op", apu_op_o, m_req ? core_op_i[w*OPW +: OPW] : '0);
        check_eq("apu_flags", apu_flags_o, m_req ? core_flags_i[w*FW +: FW] : '0);
        check_eq("core_rvalid", core_rvalid_o, rv ? (rid & m_pend) : '0);
        check_eq("outstanding", outstanding_o, m_cnt);
        check_eq("drained", drained_o, m_mode == MODE_IDLE);
        check_eq("err", err_o, m_err);
        last_id      = apu_ID_o;
        last_gnt     = core_gnt_o;
        last_rvalid  = core_rvalid_o;
        last_req     = apu_req_o;
        last_drained = drained_o;
        last_err     = err_o;
        last_out     = outstanding_o;
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Assert reset between edges, check outputs drop without a clock edge,
    // then release it with idle inputs.
    task automatic do_reset(input logic [NB-1:0] rid);
        @(negedge clk);
        #2;
        core_req_i   = '1;
        apu_gnt_i    = 1'b1;
        apu_rvalid_i = 1'b1;
        apu_rID_i    = rid;
        rst          = 1'b1;
        #1;
        check_eq("rst_apu_req", apu_req_o, 1'b0);
        check_eq("rst_apu_ID", apu_ID_o, '0);
        check_eq("rst_core_gnt", core_gnt_o, '0);
        check_eq("rst_core_rvalid", core_rvalid_o, '0);
        check_eq("rst_operands", apu_operands_o, '0);
        check_eq("rst_outstanding", outstanding_o, '0);
        check_eq("rst_drained", drained_o, 1'b0);
        check_eq("rst_err", err_o, 1'b0);
        @(posedge clk);
        #1;
        core_req_i   = '0;
        apu_gnt_i    = 1'b0;
        apu_rvalid_i = 1'b0;
        apu_rID_i    = '0;
        flush_i      = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int            fair_exp [5] = '{0, 1, 2, 3, 0};
    logic          fl_r;
    logic [NB-1:0] rid_r;

    initial begin
        model_reset();
        do_reset(4'b0001);

        // Two requesters, cap reached, core 3 waits.
        step(4'b0101, 1, 0, 4'b0000, 0);
        check_eq("t1_id0", last_id, 4'b0001);
        check_eq("t1_gnt0", last_gnt, 4'b0001);
        step(4'b0101, 1, 0, 4'b0000, 0);
        check_eq("t1_id1", last_id, 4'b0100);
        step(4'b1000, 1, 0, 4'b0000, 0);
        check_eq("t1_req_capped", last_req, 1'b0);
        check_eq("t1_out2", last_out, 2);
        // Response for core 0 frees a slot.
        step(4'b1000, 1, 1, 4'b0001, 0);
        check_eq("cap_rvalid", last_rvalid, 4'b0001);
        check_eq("cap_req_still0", last_req, 1'b0);
        // Grant core 3 while core 2 responds at cnt=1.
        step(4'b1000, 1, 1, 4'b0100, 0);
        check_eq("cap_req_back", last_req, 1'b1);
        check_eq("cap_id3", last_id, 4'b1000);
        check_eq("sim_out_before", last_out, 1);
        step(4'b0001, 1, 0, 4'b0000, 0);
        check_eq("sim_out_after", last_out, 1);
        // Drain with two in flight (cores 3 and 0).
        step(4'b1111, 1, 0, 4'b0000, 1);
        step(4'b1111, 1, 1, 4'b1000, 1);
        check_eq("drn_req0", last_req, 1'b0);
        check_eq("drn_not_done1", last_drained, 1'b0);
        step(4'b1111, 1, 1, 4'b0001, 1);
        check_eq("drn_not_done2", last_drained, 1'b0);
        step(4'b1111, 1, 0, 4'b0000, 1);
        check_eq("drn_not_done3", last_drained, 1'b0);
        step(4'b1111, 1, 0, 4'b0000, 1);
        check_eq("drn_done", last_drained, 1'b1);
        step(4'b1111, 1, 0, 4'b0000, 0);
        check_eq("drn_hold_req0", last_req, 1'b0);
        step(4'b1111, 1, 0, 4'b0000, 0);
        check_eq("drn_resume_id", last_id, 4'b0010);

        // Flush while idle: drained two cycles after flush rises.
        do_reset(4'b0000);
        step(4'b0000, 0, 0, 4'b0000, 1);
        check_eq("idle_flush_c0", last_drained, 1'b0);
        step(4'b0000, 0, 0, 4'b0000, 1);
        check_eq("idle_flush_c1", last_drained, 1'b0);
        step(4'b0000, 0, 0, 4'b0000, 1);
        check_eq("idle_flush_c2", last_drained, 1'b1);

        // Fairness: all request, each response one cycle after its grant.
        do_reset(4'b0000);
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 1, k > 0, (k > 0) ? (NB'(1) << fair_exp[(k > 0) ? k - 1 : 0]) : '0, 0);
            check_eq($sformatf("fair_gnt%0d", k), last_gnt, NB'(1) << fair_exp[k]);
        end
        step(4'b0000, 0, 1, 4'b0001, 0);

        // Randomized traffic with well-formed responses.
        fl_r = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            logic rv_r;
            rv_r  = 1'b0;
            rid_r = '0;
            if (m_pend != '0 && $urandom_range(0, 9) < 4) begin
                int c;
                c = $urandom_range(0, NB - 1);
                while (!m_pend[c]) c = (c + 1) % NB;
                rv_r  = 1'b1;
                rid_r = NB'(1) << c;
            end
            if ($urandom_range(0, 19) == 0) fl_r = ~fl_r;
            step(NB'($urandom), $urandom_range(0, 9) < 7, rv_r, rid_r, fl_r);
        end

        // Protocol errors: multi-hot ID, then a non-pending ID.
        do_reset(4'b0000);
        step(4'b0001, 1, 0, 4'b0000, 0);
        step(4'b0000, 0, 1, 4'b0011, 0);
        check_eq("err_rvalid_masked", last_rvalid, 4'b0001);
        check_eq("err_not_yet", last_err, 1'b0);
        step(4'b0000, 0, 0, 4'b0000, 0);
        check_eq("err_set", last_err, 1'b1);
        step(4'b0000, 0, 1, 4'b0100, 0);
        check_eq("err_stray_rvalid", last_rvalid, 4'b0000);
        step(4'b0000, 0, 0, 4'b0000, 0);
        check_eq("err_sticky", last_err, 1'b1);

        // Reset with core 1 in flight; its late response is flagged.
        do_reset(4'b0000);
        step(4'b0010, 1, 0, 4'b0000, 0);
        do_reset(4'b0010);
        step(4'b0000, 0, 1, 4'b0010, 0);
        check_eq("late_rvalid", last_rvalid, 4'b0000);
        step(4'b0000, 0, 0, 4'b0000, 0);
        check_eq("late_err", last_err, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpu_apu_scheduler.md
Name: fpu_apu_scheduler

Overview:
- Per-APU scheduler that shares one shared FPU/APU between NB_CORES requesting cores.
- Functions:
  - round-robin arbitration among requesting cores
  - forwards the winner's operands/op/flags with a one-hot core ID
  - caps in-flight operations at MAX_OUTSTANDING
  - routes responses back by returned ID
  - supports a drain/flush sequence for APU power-down or reconfiguration
- Sits between the core-side APU request ports and one APU master port of the FPU interconnect.

Parameters:
- NB_CORES, 4, number of requesting cores; ID width equals NB_CORES (one-hot).
- NB_APU_ARGS, 3, operands per request.
- APU_DATA_WIDTH, 64, operand/result width.
- APU_OPCODE_WIDTH, 5, opcode width.
- APU_DSFLAGS_CPU, 15, downstream flag width.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered operations (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- core_req_i  in  NB_CORES  per-core request.
- core_gnt_o  out  NB_CORES  per-core grant; at most one bit high.
- core_operands_i  in  NB_CORES*NB_APU_ARGS*APU_DATA_WIDTH  operands.
- core_op_i  in  NB_CORES*APU_OPCODE_WIDTH  opcodes.
- core_flags_i  in  NB_CORES*APU_DSFLAGS_CPU  flags.
- core_rvalid_o  out  NB_CORES  per-core response valid.
- apu_req_o  out  1  request to APU.
- apu_gnt_i  in  1  APU accepts request.
- apu_ID_o  out  NB_CORES  one-hot ID of the winning core.
- apu_operands_o  out  NB_APU_ARGS*APU_DATA_WIDTH  winner operands.
- apu_op_o  out  APU_OPCODE_WIDTH  winner opcode.
- apu_flags_o  out  APU_DSFLAGS_CPU  winner flags.
- apu_rvalid_i  in  1  APU response valid.
- apu_rID_i  in  NB_CORES  one-hot ID of the response.
- flush_i  in  1  request drain; level-sensitive.
- drained_o  out  1  drain complete; no operations in flight.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current in-flight count.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst=1):
  - rr_ptr=0, cnt=0, pending=0, state=RUN, err_o=0.
  - All outputs low/zero. drained_o=0.
- Eligibility and request:
  - eligible = core_req_i & ~pending. Each core may have at most one op in flight.
  - apu_req_o = (state==RUN) & (cnt<MAX_OUTSTANDING) & |eligible.
- Winner selection:
  - Winner = first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NB_CORES.
  - apu_ID_o = one-hot(winner). Data outputs are a combinational mux of the winner's inputs.
  - When apu_req_o=0, apu_ID_o and data outputs are 0.
- Grant handshake:
  - Accept = apu_req_o & apu_gnt_i.
  - core_gnt_o = accept ? one-hot(winner) : 0 (same cycle, combinational).
  - On accept at the clock edge: pending[winner]<=1, rr_ptr<=(winner+1) mod NB_CORES, cnt+1.
  - With no accept, rr_ptr holds. The winner may change between cycles while waiting for gnt (no request locking).
- Response:
  - core_rvalid_o = apu_rvalid_i ? (apu_rID_i & pending) : 0.
  - At the edge: pending clears those bits and cnt decrements by 1 if any bit matched.
  - err_o sets if apu_rvalid_i and (apu_rID_i not one-hot, or apu_rID_i & ~pending != 0). Unmatched bits are otherwise ignored and cnt is unchanged for them.
- Simultaneous accept and matched response: cnt unchanged; both pending updates apply. They cannot target the same core, because a pending core is not eligible.
- Counter bounds: cnt never exceeds MAX_OUTSTANDING (enforced by the request gate) and never underflows (decrement only on a pending match).
- Latency: 0-cycle request path (comb). 0-cycle response routing. State updates visible next cycle.
- State machine:
  - RUN: flush_i=1 -> DRAIN.
  - DRAIN: apu_req_o forced 0; accepted ops still complete. Transitions when cnt==0 and no response matches this cycle:
    - flush_i=1 -> DRAINED
    - flush_i=0 -> RUN
  - DRAINED: drained_o=1 (registered state decode). flush_i=0 -> RUN next cycle, drained_o falls with the state.
  - flush_i asserted while cnt==0 in RUN: DRAIN for one cycle, then DRAINED. drained_o high 2 cycles after flush_i rises.
- Reset mid-operation clears all state immediately. In-flight APU responses arriving after reset are unmatched, so err_o is set (expected; the bench must tolerate this).

Test Plan:
- NB_CORES=4, MAX=2. Cores 0,2 req; gnt_i=1 -> cycle0 apu_ID_o=0001, core_gnt_o=0001; cycle1 apu_ID_o=0100; rr_ptr=3; outstanding_o=2; apu_req_o=0 while core 3 requests.
- Fairness: all 4 req continuously, responses returned 1 cycle after each grant, MAX=4 -> grant order 0,1,2,3,0; each core granted exactly once per 4 grants.
- Outstanding cap: gnt_i=1, no responses, 4 req -> 2 accepts then apu_req_o=0. rvalid with rID=0001 -> core_rvalid_o=0001, outstanding 2->1, apu_req_o=1 next cycle.
- Simultaneous grant + response at cnt=1: outstanding_o stays 1; pending updated for both cores.
- Drain: 2 in flight, flush_i=1 -> apu_req_o=0 immediately, drained_o=0 until both responses return, then DRAINED; flush_i=0 -> RUN and arbitration resumes at saved rr_ptr.
- Error/reset: rvalid with rID=0011 or non-pending ID -> core_rvalid_o only for pending bits, err_o=1 sticky. Async rst mid-flight -> all outputs 0 without a clock edge.
